// File: rtl/pueo_trig_arb_pkg.sv
// Shared constants, FSM state type and priority helper for the PUEO trigger arbiter.
package pueo_trig_arb_pkg;

    localparam int unsigned NSRC         = 4;
    localparam int unsigned SRC_RF       = 0;
    localparam int unsigned SRC_EXT      = 1;
    localparam int unsigned SRC_PPS      = 2;
    localparam int unsigned SRC_SOFT     = 3;
    localparam int unsigned SRC_IDX_BITS = 2;
    localparam int unsigned DROP_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    // Lowest-index set bit wins (RF > EXT > PPS > SOFT).
    function automatic logic [SRC_IDX_BITS-1:0] grant_idx(input logic [NSRC-1:0] v);
        grant_idx = SRC_IDX_BITS'(SRC_SOFT);
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (v[i]) grant_idx = SRC_IDX_BITS'(i);
        end
    endfunction

endpackage

// File: rtl/pueo_trig_arb_slot.sv
// One-deep pending slot for a single trigger source: valid bit, captured timestamp
// and (with TRIG_ARB_DROPCNT_EN) a saturating drop counter.
module pueo_trig_arb_slot
    import pueo_trig_arb_pkg::*;
#(
    parameter int unsigned TIME_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req,
    input  logic                 take,
    input  logic [TIME_BITS-1:0] now,
    output logic                 valid,
    output logic [TIME_BITS-1:0] stamp
`ifdef TRIG_ARB_DROPCNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [DROP_BITS-1:0] drop_cnt
`endif
);

    // Slot capture: a grant clears before a same-cycle request refills.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            stamp <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (take) begin
            valid <= req;
            if (req) stamp <= now;
        end else if (req && !valid) begin
            valid <= 1'b1;
            stamp <= now;
        end
    end

`ifdef TRIG_ARB_DROPCNT_EN
    // Count requests that hit an occupied slot, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (cnt_clr) begin
            drop_cnt <= '0;
        end else if (!flush && !take && req && valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_BITS'(1);
        end
    end
`endif

endmodule

// File: rtl/pueo_trig_arbiter.sv
// PUEO trigger arbiter: four one-deep request slots, fixed-priority grant onto an
// AXI4-Stream output, followed by a programmable deadtime.
// Optional feature macro: TRIG_ARB_DROPCNT_EN adds per-source drop counters (drop_cnt_o).
module pueo_trig_arbiter
    import pueo_trig_arb_pkg::*;
#(
    parameter int unsigned TIME_BITS    = 32,
    parameter int unsigned HOLDOFF_BITS = 16
) (
    input  logic                    sysclk_i,
    input  logic                    rst_i,
    input  logic                    runrst_i,
    input  logic                    run_en_i,
    input  logic [TIME_BITS-1:0]    cur_time_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic [NSRC-1:0]         src_req_i,
    output logic [TIME_BITS+3:0]    trig_tdata,
    output logic                    trig_tvalid,
    input  logic                    trig_tready
`ifdef TRIG_ARB_DROPCNT_EN
    ,
    output logic [NSRC-1:0][DROP_BITS-1:0] drop_cnt_o
`endif
);

    logic [1:0]                rst_sync;
    logic                      init_hold;
    logic                      run_clr;
    logic                      flush;
    logic [NSRC-1:0]           valid;
    logic [TIME_BITS-1:0]      stamp [NSRC];
    logic [NSRC-1:0]           take;
    logic [SRC_IDX_BITS-1:0]   gidx;
    logic [SRC_IDX_BITS-1:0]   gsrc;
    logic [HOLDOFF_BITS-1:0]   hold_cnt;
    logic                      load_grant;
    logic                      handshake;
    state_t                    state, state_next;

    // Hold the core in run-reset for two cycles after rst_i releases.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end

    assign init_hold = rst_sync[1];
    assign run_clr   = runrst_i | init_hold;
    assign flush     = run_clr | ~run_en_i;
    assign gidx      = grant_idx(valid);

    for (genvar g = 0; g < int'(NSRC); g++) begin : g_slot
        pueo_trig_arb_slot #(.TIME_BITS(TIME_BITS)) u_slot (
            .clk      (sysclk_i),
            .rst      (rst_i),
            .flush    (flush),
            .req      (src_req_i[g]),
            .take     (take[g]),
            .now      (cur_time_i),
            .valid    (valid[g]),
            .stamp    (stamp[g])
`ifdef TRIG_ARB_DROPCNT_EN
            ,
            .cnt_clr  (run_clr),
            .drop_cnt (drop_cnt_o[g])
`endif
        );
    end

    // FSM state register.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and grant/handshake decode; run reset overrides everything.
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        handshake  = 1'b0;
        take       = '0;
        if (run_clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run_en_i && (|valid)) begin
                        load_grant = 1'b1;
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (trig_tready) begin
                        handshake  = 1'b1;
                        take[gsrc] = 1'b1;
                        state_next = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output register, granted-source latch and deadtime counter.
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_tvalid <= 1'b0;
            trig_tdata  <= '0;
            gsrc        <= '0;
            hold_cnt    <= '0;
        end else if (run_clr) begin
            trig_tvalid <= 1'b0;
            hold_cnt    <= '0;
        end else if (load_grant) begin
            trig_tvalid <= 1'b1;
            trig_tdata  <= {valid, stamp[gidx]};
            gsrc        <= gidx;
        end else if (handshake) begin
            trig_tvalid <= 1'b0;
            hold_cnt    <= holdoff_i;
        end else if ((state == HOLDOFF) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HOLDOFF_BITS'(1);
        end
    end

endmodule

// File: tb/tb_pueo_trig_arbiter.sv
// Self-checking bench for pueo_trig_arbiter: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural model of the slot/grant rules.
module tb_pueo_trig_arbiter;

    logic        sysclk = 1'b0;
    logic        rst    = 1'b1;
    logic        runrst = 1'b0;
    logic        run_en = 1'b1;
    logic [31:0] t_now  = '0;
    logic [15:0] holdoff = 16'd10;
    logic [3:0]  req    = '0;
    logic        ready  = 1'b1;
    logic [35:0] tdata;
    logic        tvalid;
`ifdef TRIG_ARB_DROPCNT_EN
    logic [3:0][15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: per-source pending slots, a phase (0 idle, 1 issuing, 2 deadtime) and output.
    bit [3:0]    m_v;
    logic [31:0] m_t [4];
    int          m_phase;
    int          m_left;
    int          m_gsrc;
    bit          m_tvalid;
    logic [35:0] m_tdata;
    int          m_drop [4];
    int          m_hold;

    pueo_trig_arbiter dut (
        .sysclk_i    (sysclk),
        .rst_i       (rst),
        .runrst_i    (runrst),
        .run_en_i    (run_en),
        .cur_time_i  (t_now),
        .holdoff_i   (holdoff),
        .src_req_i   (req),
        .trig_tdata  (tdata),
        .trig_tvalid (tvalid),
        .trig_tready (ready)
`ifdef TRIG_ARB_DROPCNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_v      = '0;
        m_phase  = 0;
        m_left   = 0;
        m_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) m_drop[i] = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int take;
        bit [3:0] old_v;
        if (rst) begin
            model_clear();
            m_tdata = '0;
            m_gsrc  = 0;
            m_hold  = 2;
            return;
        end
        if (runrst || m_hold > 0) begin
            if (m_hold > 0) m_hold--;
            model_clear();
            return;
        end
        take  = -1;
        old_v = m_v;
        if (m_phase == 0) begin
            if (run_en && old_v != 0) begin
                int g;
                g = 3;
                for (int i = 3; i >= 0; i--) if (old_v[i]) g = i;
                m_tdata  = {old_v, m_t[g]};
                m_tvalid = 1'b1;
                m_gsrc   = g;
                m_phase  = 1;
            end
        end else if (m_phase == 1) begin
            if (ready) begin
                m_tvalid = 1'b0;
                take     = m_gsrc;
                m_left   = int'(holdoff) + 1;
                m_phase  = 2;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
        if (!run_en) begin
            m_v = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i == take) begin
                    m_v[i] = req[i];
                    if (req[i]) m_t[i] = t_now;
                end else if (req[i]) begin
                    if (old_v[i]) begin
                        if (m_drop[i] < 65535) m_drop[i]++;
                    end else begin
                        m_v[i] = 1'b1;
                        m_t[i] = t_now;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", tvalid, m_tvalid);
        if (m_tvalid) chk("tdata", tdata, m_tdata);
`ifdef TRIG_ARB_DROPCNT_EN
        for (int i = 0; i < 4; i++) chk("drop_cnt", drop_cnt[i], 64'(m_drop[i]));
`endif
    endtask

    task automatic tick();
        model_step();
        @(negedge sysclk);
        check_outputs();
        t_now = t_now + 32'd1;
    endtask

    task automatic pulse(input logic [3:0] r);
        req = r;
        tick();
        req = '0;
    endtask

    // Wait (bounded) for tvalid; a timeout counts as a failed comparison.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!tvalid && n < 60) begin
            tick();
            n++;
        end
        if (!tvalid) chk(tag, 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        bit seen;
        logic [35:0] held;
        logic [31:0] soft_t;

        model_clear();
        m_hold  = 2;
        m_gsrc  = 0;
        m_tdata = '0;
        @(negedge sysclk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // Single PPS request, latency and deadtime.
        holdoff = 16'd10;
        ready   = 1'b1;
        t_now   = 32'd100;
        pulse(4'b0100);
        chk("lat_n1", tvalid, 0);
        tick();
        chk("lat_n2", tvalid, 1);
        chk("lat_data", tdata, {4'b0100, 32'd100});
        req = 4'b1000;
        n = 0;
        while (n < 40) begin
            tick();
            req = '0;
            n++;
            if (tvalid) break;
        end
        chk("holdoff_gap", 64'(n), 64'd13);
        tick();

        // Coincident RF + SOFT.
        holdoff = 16'd3;
        repeat (16) tick();
        t_now = 32'd500;
        pulse(4'b1001);
        tick();
        chk("coin_first", tdata, {4'b1001, 32'd500});
        tick();
        wait_valid("coin_timeout", n);
        chk("coin_second", tdata, {4'b1000, 32'd500});
        tick();
        repeat (8) tick();

        // Backpressure with a SOFT request queued behind.
        ready = 1'b0;
        t_now = 32'd700;
        pulse(4'b0010);
        tick();
        held = tdata;
        chk("bp_data", held, {4'b0010, 32'd700});
        soft_t = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                soft_t = t_now;
                req = 4'b1000;
            end
            tick();
            req = '0;
            chk("bp_tvalid", tvalid, 1);
            chk("bp_stable", tdata, held);
        end
        ready = 1'b1;
        tick();
        wait_valid("bp_timeout", n);
        chk("bp_soft", tdata, {4'b1000, soft_t});
        tick();
        repeat (8) tick();

        // Drop: two EXT pulses during deadtime.
        holdoff = 16'd10;
        pulse(4'b0001);
        tick();
        tick();
        t_now = 32'd900;
        pulse(4'b0010);
        tick();
        tick();
        pulse(4'b0010);
        wait_valid("drop_timeout", n);
        chk("drop_data", tdata, {4'b0010, 32'd900});
`ifdef TRIG_ARB_DROPCNT_EN
        chk("drop_ext", drop_cnt[1], 64'd1);
`endif
        tick();
        repeat (14) tick();

        // Asynchronous reset during ISSUE.
        ready = 1'b0;
        pulse(4'b0100);
        tick();
        chk("issue_before_rst", tvalid, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_tvalid", tvalid, 0);
        tick();
        rst   = 1'b0;
        ready = 1'b1;
        repeat (4) tick();

        // Run reset during deadtime with PPS pending.
        holdoff = 16'd10;
        pulse(4'b0001);
        tick();
        tick();
        pulse(4'b0100);
        tick();
        runrst = 1'b1;
        tick();
        runrst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen |= tvalid;
        end
        chk("runrst_no_out", seen, 0);

        // Run disable with RF pending.
        pulse(4'b0001);
        tick();
        tick();
        pulse(4'b0001);
        run_en = 1'b0;
        seen = 1'b0;
        tick();
        pulse(4'b1111);
        repeat (30) begin
            tick();
            seen |= tvalid;
        end
        run_en = 1'b1;
        repeat (20) begin
            tick();
            seen |= tvalid;
        end
        chk("runen_no_out", seen, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (i % 97 == 0) holdoff = 16'($urandom_range(0, 7));
            for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 7) == 0);
            ready  = ($urandom_range(0, 9) < 7);
            run_en = !((i % 500) >= 460);
            runrst = ($urandom_range(0, 399) == 0);
            tick();
        end
        req    = '0;
        runrst = 1'b0;
        run_en = 1'b1;
        ready  = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
